// File: rtl/gpu_pkg.sv
// gpu_pkg
// Shared encodings for the per-core pipeline. The core execution manager and
// the instruction fetcher both import this package, so the state codes they
// exchange stay in one place.
// Ports: none (package).
package gpu_pkg;

    // Core execution manager states, as seen on the fetcher's core_state input.
    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    // Fetcher states reported back to the manager.
    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_t;

    localparam int COUNTER_BITS = 16;

    // Saturating increment: an all-ones counter holds instead of wrapping to 0.
    function automatic logic [COUNTER_BITS-1:0] sat_inc(input logic [COUNTER_BITS-1:0] value);
        if (&value) begin
            return value;
        end
        return value + COUNTER_BITS'(1);
    endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array
// Storage for a direct-mapped instruction cache: one valid bit, tag and data
// word per line. Reads are combinational, writes land on the rising clock edge.
// Flush clears every valid bit on the next edge and takes priority over a
// write in the same cycle. Reset clears every valid bit asynchronously; the tag
// and data arrays are left alone because an invalid line is never consulted.
// Ports:
//   clk, reset                  clock, async active-high reset
//   flush                       invalidate all lines on the next edge
//   read_index                  line to look up
//   read_valid/tag/data         contents of that line
//   write_enable                allocate write_index with write_tag/write_data
//   write_index/tag/data        fill address and contents
module icache_array #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LINES     = 8,
    localparam int IDX_BITS = $clog2(LINES),
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [IDX_BITS-1:0]  read_index,
    output logic                 read_valid,
    output logic [TAG_BITS-1:0]  read_tag,
    output logic [DATA_BITS-1:0] read_data,
    input  logic                 write_enable,
    input  logic [IDX_BITS-1:0]  write_index,
    input  logic [TAG_BITS-1:0]  write_tag,
    input  logic [DATA_BITS-1:0] write_data
);

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_ram  [LINES];
    logic [DATA_BITS-1:0] data_ram [LINES];

    // Flush wins over a fill in the same cycle so a flushed cache is really empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (write_enable) begin
            valid_q[write_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (write_enable) begin
            tag_ram[write_index]  <= write_tag;
            data_ram[write_index] <= write_data;
        end
    end

    assign read_valid = valid_q[read_index];
    assign read_tag   = tag_ram[read_index];
    assign read_data  = data_ram[read_index];

endmodule

// File: rtl/cached_fetcher.sv
// cached_fetcher
// Per-core instruction fetch stage. When the manager is in FETCH and the
// fetcher is IDLE, current_pc is looked up in a small direct-mapped cache.
// A hit delivers the instruction one cycle later; a miss issues one read on
// the program-memory valid/ready channel and fills the line when it returns.
// Hit and miss counters saturate at all-ones.
// Ports:
//   clk, reset          clock, async active-high reset
//   core_state          manager state (gpu_pkg::core_state_t encoding)
//   current_pc          address to fetch, stable while core_state == FETCH
//   flush               one-cycle pulse invalidating the whole cache
//   mem_read_valid      read request to the program-memory controller
//   mem_read_address    request address (latched PC)
//   mem_read_ready      memory returns mem_read_data this cycle
//   mem_read_data       returned instruction word
//   fetcher_state       IDLE / FETCHING / FETCHED
//   instruction         fetched word, valid while fetcher_state == FETCHED
//   hit_count           saturating cache-hit counter
//   miss_count          saturating cache-miss counter
// HIT_COUNT_RESET / MISS_COUNT_RESET are bring-up aids for the counters;
// production instances leave them at 0.
module cached_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 8,
    parameter logic [COUNTER_BITS-1:0] HIT_COUNT_RESET  = '0,
    parameter logic [COUNTER_BITS-1:0] MISS_COUNT_RESET = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [COUNTER_BITS-1:0]          hit_count,
    output logic [COUNTER_BITS-1:0]          miss_count
);

    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

    fetcher_state_t                   state_q, state_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instruction_q, instruction_d;
    logic                             req_valid_q, req_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] req_address_q, req_address_d;
    logic                             flush_seen_q, flush_seen_d;
    logic [COUNTER_BITS-1:0]          hit_count_q, miss_count_q;

    logic                             hit_event;
    logic                             miss_event;
    logic                             fill_enable;

    logic [IDX_BITS-1:0]              pc_index;
    logic [TAG_BITS-1:0]              pc_tag;
    logic                             line_valid;
    logic [TAG_BITS-1:0]              line_tag;
    logic [PROGRAM_MEM_DATA_BITS-1:0] line_data;
    logic                             lookup_hit;

    assign pc_index = current_pc[IDX_BITS-1:0];
    assign pc_tag   = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];

    // Fills always target the latched request address, never the live PC.
    icache_array #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .LINES     (CACHE_LINES)
    ) u_icache_array (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .read_index   (pc_index),
        .read_valid   (line_valid),
        .read_tag     (line_tag),
        .read_data    (line_data),
        .write_enable (fill_enable),
        .write_index  (req_address_q[IDX_BITS-1:0]),
        .write_tag    (req_address_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS]),
        .write_data   (mem_read_data)
    );

    assign lookup_hit = line_valid && (line_tag == pc_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCHER_IDLE;
            instruction_q <= '0;
            req_valid_q   <= 1'b0;
            req_address_q <= '0;
            flush_seen_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            instruction_q <= instruction_d;
            req_valid_q   <= req_valid_d;
            req_address_q <= req_address_d;
            flush_seen_q  <= flush_seen_d;
        end
    end

    // A flush coinciding with a lookup forces the miss path, because the line
    // being read is invalid from the next edge on. A flush at any point while a
    // fill is outstanding is remembered in flush_seen so the returning word is
    // delivered but not allocated.
    always_comb begin
        state_d       = state_q;
        instruction_d = instruction_q;
        req_valid_d   = req_valid_q;
        req_address_d = req_address_q;
        flush_seen_d  = flush_seen_q;
        hit_event     = 1'b0;
        miss_event    = 1'b0;
        fill_enable   = 1'b0;

        case (state_q)
            FETCHER_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (lookup_hit && !flush) begin
                        instruction_d = line_data;
                        state_d       = FETCHER_FETCHED;
                        hit_event     = 1'b1;
                    end else begin
                        req_valid_d   = 1'b1;
                        req_address_d = current_pc;
                        flush_seen_d  = 1'b0;
                        state_d       = FETCHER_FETCHING;
                        miss_event    = 1'b1;
                    end
                end
            end
            FETCHER_FETCHING: begin
                if (flush) begin
                    flush_seen_d = 1'b1;
                end
                if (mem_read_ready) begin
                    instruction_d = mem_read_data;
                    req_valid_d   = 1'b0;
                    state_d       = FETCHER_FETCHED;
                    fill_enable   = !(flush || flush_seen_q);
                    flush_seen_d  = 1'b0;
                end
            end
            FETCHER_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_d = FETCHER_IDLE;
                end
            end
            default: begin
                state_d     = FETCHER_IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_q  <= HIT_COUNT_RESET;
            miss_count_q <= MISS_COUNT_RESET;
        end else begin
            if (hit_event) begin
                hit_count_q <= sat_inc(hit_count_q);
            end
            if (miss_event) begin
                miss_count_q <= sat_inc(miss_count_q);
            end
        end
    end

    assign mem_read_valid   = req_valid_q;
    assign mem_read_address = req_address_q;
    assign fetcher_state    = state_q;
    assign instruction      = instruction_q;
    assign hit_count        = hit_count_q;
    assign miss_count       = miss_count_q;

endmodule

// File: tb/tb_cached_fetcher.sv
// tb_cached_fetcher
// Directed bench for cached_fetcher. Two instances share every input: dut
// uses default counter reset values, sat_dut starts its counters near
// all-ones so saturation shows up within a few transactions.
module tb_cached_fetcher;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        flush;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;

    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic        sat_mem_read_valid;
    logic [7:0]  sat_mem_read_address;
    logic [2:0]  sat_fetcher_state;
    logic [15:0] sat_instruction;
    logic [15:0] sat_hit_count;
    logic [15:0] sat_miss_count;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    always #5 clk = ~clk;

    cached_fetcher dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .flush            (flush),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    cached_fetcher #(
        .HIT_COUNT_RESET  (16'hFFFD),
        .MISS_COUNT_RESET (16'hFFFE)
    ) sat_dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .flush            (flush),
        .mem_read_valid   (sat_mem_read_valid),
        .mem_read_address (sat_mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (sat_fetcher_state),
        .instruction      (sat_instruction),
        .hit_count        (sat_hit_count),
        .miss_count       (sat_miss_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] cs, input logic [7:0] pc, input logic fl,
                                 input logic rdy, input logic [15:0] data);
        core_state     = cs;
        current_pc     = pc;
        flush          = fl;
        mem_read_ready = rdy;
        mem_read_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] sat_exp(input int base, input int n);
        int s;
        s = base + n;
        return (s > 65535) ? 32'hFFFF : 32'(s);
    endfunction

    task automatic check_counters(input string tag);
        checkOutput({tag, ".hits"},       32'(hit_count),      32'(exp_hits));
        checkOutput({tag, ".misses"},     32'(miss_count),     32'(exp_misses));
        checkOutput({tag, ".sat_hits"},   32'(sat_hit_count),  sat_exp(32'hFFFD, exp_hits));
        checkOutput({tag, ".sat_misses"}, 32'(sat_miss_count), sat_exp(32'hFFFE, exp_misses));
    endtask

    task automatic fetch_miss(input logic [7:0] pc, input logic [15:0] data, input string tag);
        applyStimulus(CORE_FETCH, pc, 1'b0, 1'b0, 16'h0000);
        tick();
        exp_misses++;
        checkOutput({tag, ".req_state"}, 32'(fetcher_state),    32'(FETCHER_FETCHING));
        checkOutput({tag, ".req_valid"}, 32'(mem_read_valid),   32'd1);
        checkOutput({tag, ".req_addr"},  32'(mem_read_address), 32'(pc));
        applyStimulus(CORE_FETCH, pc, 1'b0, 1'b1, data);
        tick();
        checkOutput({tag, ".state"},     32'(fetcher_state),  32'(FETCHER_FETCHED));
        checkOutput({tag, ".instr"},     32'(instruction),    32'(data));
        checkOutput({tag, ".valid_low"}, 32'(mem_read_valid), 32'd0);
        check_counters(tag);
        applyStimulus(CORE_DECODE, pc, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput({tag, ".idle"}, 32'(fetcher_state), 32'(FETCHER_IDLE));
    endtask

    task automatic fetch_hit(input logic [7:0] pc, input logic [15:0] data, input string tag);
        applyStimulus(CORE_FETCH, pc, 1'b0, 1'b0, 16'h0000);
        tick();
        exp_hits++;
        checkOutput({tag, ".state"},    32'(fetcher_state),  32'(FETCHER_FETCHED));
        checkOutput({tag, ".instr"},    32'(instruction),    32'(data));
        checkOutput({tag, ".no_req"},   32'(mem_read_valid), 32'd0);
        check_counters(tag);
        applyStimulus(CORE_DECODE, pc, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput({tag, ".idle"}, 32'(fetcher_state), 32'(FETCHER_IDLE));
    endtask

    initial begin
        // Reset: every output of dut is zero, sat_dut holds its preloads.
        applyStimulus(CORE_IDLE, 8'h00, 1'b0, 1'b0, 16'h0000);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("reset.state", 32'(fetcher_state),    32'(FETCHER_IDLE));
        checkOutput("reset.valid", 32'(mem_read_valid),   32'd0);
        checkOutput("reset.addr",  32'(mem_read_address), 32'd0);
        checkOutput("reset.instr", 32'(instruction),      32'd0);
        check_counters("reset");
        reset = 1'b0;
        tick();

        // Cold miss with a three-cycle memory response.
        applyStimulus(CORE_FETCH, 8'h05, 1'b0, 1'b0, 16'h0000);
        tick();
        exp_misses++;
        checkOutput("cold.state",    32'(fetcher_state),    32'(FETCHER_FETCHING));
        checkOutput("cold.valid_c1", 32'(mem_read_valid),   32'd1);
        checkOutput("cold.addr_c1",  32'(mem_read_address), 32'h05);
        check_counters("cold.issue");
        tick();
        checkOutput("cold.valid_c2", 32'(mem_read_valid),   32'd1);
        checkOutput("cold.addr_c2",  32'(mem_read_address), 32'h05);
        tick();
        checkOutput("cold.valid_c3", 32'(mem_read_valid),   32'd1);
        checkOutput("cold.addr_c3",  32'(mem_read_address), 32'h05);
        applyStimulus(CORE_FETCH, 8'h05, 1'b0, 1'b1, 16'h3A17);
        tick();
        checkOutput("cold.fetched", 32'(fetcher_state),  32'(FETCHER_FETCHED));
        checkOutput("cold.instr",   32'(instruction),    32'h3A17);
        checkOutput("cold.valid_0", 32'(mem_read_valid), 32'd0);
        check_counters("cold.done");
        // FETCH while FETCHED must not start a new lookup.
        applyStimulus(CORE_FETCH, 8'h05, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("cold.hold_state", 32'(fetcher_state), 32'(FETCHER_FETCHED));
        checkOutput("cold.hold_instr", 32'(instruction),   32'h3A17);
        check_counters("cold.hold");
        applyStimulus(CORE_DECODE, 8'h05, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("cold.idle", 32'(fetcher_state), 32'(FETCHER_IDLE));

        // Hit on the same PC.
        fetch_hit(8'h05, 16'h3A17, "hit05");

        // Conflict on index 5, then an unrelated index that must not evict it.
        fetch_miss(8'h0D, 16'h1111, "conflict0d");
        fetch_miss(8'h05, 16'h3A17, "conflict05");
        fetch_hit(8'h05, 16'h3A17, "rehit05");
        fetch_miss(8'h02, 16'hBEEF, "miss02");
        fetch_hit(8'h02, 16'hBEEF, "hit02");
        fetch_hit(8'h05, 16'h3A17, "hit05_kept");

        // Flush while idle invalidates the cache and leaves the state alone.
        applyStimulus(CORE_IDLE, 8'h00, 1'b1, 1'b0, 16'h0000);
        tick();
        applyStimulus(CORE_IDLE, 8'h00, 1'b0, 1'b0, 16'h0000);
        checkOutput("flush_idle.state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        fetch_miss(8'h05, 16'h3A17, "flush_idle05");

        // Flush coinciding with a lookup of a valid line forces a miss.
        applyStimulus(CORE_FETCH, 8'h05, 1'b1, 1'b0, 16'h0000);
        tick();
        exp_misses++;
        checkOutput("flush_lookup.state", 32'(fetcher_state),  32'(FETCHER_FETCHING));
        checkOutput("flush_lookup.valid", 32'(mem_read_valid), 32'd1);
        applyStimulus(CORE_FETCH, 8'h05, 1'b0, 1'b1, 16'h3A17);
        tick();
        checkOutput("flush_lookup.instr", 32'(instruction), 32'h3A17);
        check_counters("flush_lookup");
        applyStimulus(CORE_DECODE, 8'h05, 1'b0, 1'b0, 16'h0000);
        tick();
        fetch_hit(8'h05, 16'h3A17, "flush_lookup_refill");

        // Flush during FETCHING: delivered but not allocated.
        applyStimulus(CORE_FETCH, 8'h13, 1'b0, 1'b0, 16'h0000);
        tick();
        exp_misses++;
        checkOutput("flush_fill.req", 32'(fetcher_state), 32'(FETCHER_FETCHING));
        applyStimulus(CORE_FETCH, 8'h13, 1'b1, 1'b0, 16'h0000);
        tick();
        checkOutput("flush_fill.state_kept", 32'(fetcher_state),    32'(FETCHER_FETCHING));
        checkOutput("flush_fill.valid_kept", 32'(mem_read_valid),   32'd1);
        checkOutput("flush_fill.addr_kept",  32'(mem_read_address), 32'h13);
        applyStimulus(CORE_FETCH, 8'h13, 1'b0, 1'b1, 16'h7777);
        tick();
        checkOutput("flush_fill.state", 32'(fetcher_state), 32'(FETCHER_FETCHED));
        checkOutput("flush_fill.instr", 32'(instruction),   32'h7777);
        applyStimulus(CORE_DECODE, 8'h13, 1'b0, 1'b0, 16'h0000);
        tick();
        fetch_miss(8'h13, 16'h7777, "after_flush_fill13");
        fetch_hit(8'h13, 16'h7777, "hit13");
        fetch_miss(8'h05, 16'h3A17, "after_flush_fill05");

        // Asynchronous reset in the middle of a fill.
        applyStimulus(CORE_FETCH, 8'h21, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("midreset.req", 32'(fetcher_state), 32'(FETCHER_FETCHING));
        #2;
        reset = 1'b1;
        #1;
        exp_hits   = 0;
        exp_misses = 0;
        checkOutput("midreset.state", 32'(fetcher_state),    32'(FETCHER_IDLE));
        checkOutput("midreset.valid", 32'(mem_read_valid),   32'd0);
        checkOutput("midreset.addr",  32'(mem_read_address), 32'd0);
        checkOutput("midreset.instr", 32'(instruction),      32'd0);
        check_counters("midreset");
        #1;
        reset = 1'b0;
        applyStimulus(CORE_IDLE, 8'h21, 1'b0, 1'b1, 16'hDEAD);
        tick();
        checkOutput("late_ready.state", 32'(fetcher_state),  32'(FETCHER_IDLE));
        checkOutput("late_ready.valid", 32'(mem_read_valid), 32'd0);
        checkOutput("late_ready.instr", 32'(instruction),    32'd0);
        fetch_miss(8'h21, 16'h4242, "post_reset21");

        // Counter saturation on sat_dut, and FETCHED held under FETCH.
        fetch_hit(8'h21, 16'h4242, "sat_hit1");
        fetch_hit(8'h21, 16'h4242, "sat_hit2");
        applyStimulus(CORE_FETCH, 8'h21, 1'b0, 1'b0, 16'h0000);
        tick();
        exp_hits++;
        checkOutput("sat_hold.state", 32'(fetcher_state), 32'(FETCHER_FETCHED));
        check_counters("sat_hit3");
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("sat_hold.held", 32'(fetcher_state), 32'(FETCHER_FETCHED));
            checkOutput("sat_hold.instr", 32'(instruction),  32'h4242);
            check_counters("sat_hold");
        end
        applyStimulus(CORE_DECODE, 8'h21, 1'b0, 1'b0, 16'h0000);
        tick();
        fetch_miss(8'h31, 16'h5555, "sat_miss31");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
